// File: rtl/score_lives_keeper.sv
// score_lives_keeper: game-level controller keeping a BCD score, high score and lives,
// and holding the falling-letter column outside active play.
module score_lives_keeper #(
   parameter int LIVES          = 3,
   parameter int LIVES_W        = 2,
   parameter int RESPAWN_CYCLES = 25000000
) (
   input  logic               clock,
   input  logic               reset_signal,
   input  logic               start_button,
   input  logic               correct,
   input  logic               game_over,
   output logic               column_hold,
   output logic [15:0]        score,
   output logic [15:0]        high_score,
   output logic [LIVES_W-1:0] lives,
   output logic               playing,
   output logic               game_ended
);
   localparam int CW = $clog2(RESPAWN_CYCLES);
   typedef enum logic [1:0] {IDLE, PLAYING, RESPAWN, OVER} state_t;
   state_t             state_q, state_d;
   logic               sync1_q, sync2_q, sync3_q;
   logic               correct_q, miss_q;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [15:0]        score_q, score_d, high_q, high_d, scored, inc;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic               hold_q, playing_q, ended_q;
   logic               start_pulse, correct_rise, miss_rise, carry;
   assign start_pulse  = sync2_q & ~sync3_q;
   assign correct_rise = correct & ~correct_q;
   assign miss_rise    = game_over & ~miss_q;
   // Ripple carry through the four BCD digits; 9999 saturates rather than wrapping.
   always_comb begin
      inc   = score_q;
      carry = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (carry) begin
            carry          = inc[4*k +: 4] == 4'd9;
            inc[4*k +: 4]  = carry ? 4'd0 : inc[4*k +: 4] + 4'd1;
         end
      end
      scored = (correct_rise && score_q != 16'h9999) ? inc : score_q;
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      score_d = score_q;
      high_d  = high_q;
      lives_d = lives_q;
      case (state_q)
         IDLE, OVER: begin
            if (start_pulse) begin
               state_d = PLAYING;
               score_d = '0;
               lives_d = LIVES_W'(LIVES);
            end
         end
         PLAYING: begin
            score_d = scored;
            if (miss_rise) begin
               if (lives_q > LIVES_W'(1)) begin
                  lives_d = lives_q - LIVES_W'(1);
                  state_d = RESPAWN;
                  cnt_d   = '0;
               end else begin
                  lives_d = '0;
                  state_d = OVER;
                  high_d  = scored > high_q ? scored : high_q;
               end
            end
         end
         RESPAWN: begin
            cnt_d   = cnt_q + CW'(1);
            state_d = cnt_q == CW'(RESPAWN_CYCLES - 1) ? PLAYING : RESPAWN;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         state_q   <= IDLE;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         sync3_q   <= 1'b0;
         correct_q <= 1'b0;
         miss_q    <= 1'b0;
         cnt_q     <= '0;
         score_q   <= '0;
         high_q    <= '0;
         lives_q   <= LIVES_W'(LIVES);
         hold_q    <= 1'b1;
         playing_q <= 1'b0;
         ended_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= start_button;
         sync2_q   <= sync1_q;
         sync3_q   <= sync2_q;
         correct_q <= correct;
         miss_q    <= game_over;
         cnt_q     <= cnt_d;
         score_q   <= score_d;
         high_q    <= high_d;
         lives_q   <= lives_d;
         hold_q    <= state_d != PLAYING;
         playing_q <= state_d == PLAYING || state_d == RESPAWN;
         ended_q   <= state_d == OVER;
      end
   end
   assign column_hold = hold_q;
   assign score       = score_q;
   assign high_score  = high_q;
   assign lives       = lives_q;
   assign playing     = playing_q;
   assign game_ended  = ended_q;
endmodule

// File: tb/tb_score_lives_keeper.sv
// tb_score_lives_keeper: directed vector table plus hand sequences for score_lives_keeper.
module tb_score_lives_keeper;
   logic        clock = 1'b0;
   logic        reset_signal = 1'b1;
   logic        start_button = 1'b0;
   logic        correct = 1'b0;
   logic        game_over = 1'b0;
   logic        column_hold, playing, game_ended;
   logic [15:0] score, high_score;
   logic [1:0]  lives;
   int          n_cmp = 0;
   int          n_err = 0;
   typedef struct {
      logic        st, co, go, h;
      logic [15:0] sc;
      logic [1:0]  lv;
      logic        pl, en;
   } vec_t;
   vec_t vecs[22];
   score_lives_keeper #(.LIVES(3), .LIVES_W(2), .RESPAWN_CYCLES(4)) dut (
      .clock(clock), .reset_signal(reset_signal), .start_button(start_button),
      .correct(correct), .game_over(game_over), .column_hold(column_hold),
      .score(score), .high_score(high_score), .lives(lives),
      .playing(playing), .game_ended(game_ended)
   );
   always #5 clock = ~clock;
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask
   task automatic chk_all(input string nm, input logic h, input logic [15:0] sc,
                          input logic [1:0] lv, input logic pl, input logic en);
      chk({nm, ".hold"}, {15'd0, column_hold}, {15'd0, h});
      chk({nm, ".score"}, score, sc);
      chk({nm, ".lives"}, {14'd0, lives}, {14'd0, lv});
      chk({nm, ".playing"}, {15'd0, playing}, {15'd0, pl});
      chk({nm, ".ended"}, {15'd0, game_ended}, {15'd0, en});
   endtask
   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         correct = 1'b1;
         tick();
         correct = 1'b0;
         tick();
      end
   endtask
   task automatic miss();
      int k;
      game_over = 1'b1;
      tick();
      game_over = 1'b0;
      tick();
      k = 0;
      while (column_hold && playing && k < 20) begin
         tick();
         k++;
      end
      if (k >= 20) begin
         n_cmp++;
         n_err++;
         $display("FAIL respawn_timeout: still holding after %0d cycles", k);
      end
   endtask
   task automatic press();
      start_button = 1'b1;
      repeat (5) tick();
      start_button = 1'b0;
      tick();
   endtask
   initial begin
      //            st    co    go    h     score    lv    pl    en
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 2'd3, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 2'd3, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd3, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd3, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd3, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd3, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 2'd3, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 2'd3, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 2'd3, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 2'd3, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 2'd3, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0002, 2'd2, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 2'd2, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 2'd2, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 2'd2, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 2'd2, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 2'd2, 1'b1, 1'b0};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 2'd2, 1'b1, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 2'd2, 1'b1, 1'b0};
      vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 2'd2, 1'b1, 1'b0};
      vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 2'd2, 1'b1, 1'b0};
      vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 2'd2, 1'b1, 1'b0};
      #3 reset_signal = 1'b0;
      #1;
      chk_all("reset", 1'b1, 16'h0000, 2'd3, 1'b0, 1'b0);
      chk("reset.high", high_score, 16'h0000);
      tick();
      tick();
      reset_signal = 1'b1;
      tick();
      for (int i = 0; i < 22; i++) begin
         start_button = vecs[i].st;
         correct      = vecs[i].co;
         game_over    = vecs[i].go;
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].h, vecs[i].sc, vecs[i].lv, vecs[i].pl, vecs[i].en);
      end
      pulses(9);
      chk("score_12", score, 16'h0012);
      pulses(987);
      chk("score_999", score, 16'h0999);
      pulses(1);
      chk("carry_1000", score, 16'h1000);
      pulses(8999);
      chk("score_9999", score, 16'h9999);
      pulses(1);
      chk("saturate", score, 16'h9999);
      game_over = 1'b1;
      tick();
      game_over = 1'b0;
      tick();
      chk("respawn_hold", {15'd0, column_hold}, 16'd1);
      #2 reset_signal = 1'b0;
      #1;
      chk_all("reset_mid", 1'b1, 16'h0000, 2'd3, 1'b0, 1'b0);
      chk("reset_mid.high", high_score, 16'h0000);
      tick();
      reset_signal = 1'b1;
      tick();
      press();
      chk_all("game2_start", 1'b0, 16'h0000, 2'd3, 1'b1, 1'b0);
      correct = 1'b1;
      repeat (10) tick();
      correct = 1'b0;
      tick();
      chk("held_once", score, 16'h0001);
      pulses(4);
      miss();
      miss();
      chk_all("one_life", 1'b0, 16'h0005, 2'd1, 1'b1, 1'b0);
      miss();
      chk_all("over", 1'b1, 16'h0005, 2'd0, 1'b0, 1'b1);
      chk("high_5", high_score, 16'h0005);
      pulses(2);
      chk("over_frozen", score, 16'h0005);
      press();
      chk_all("restart", 1'b0, 16'h0000, 2'd3, 1'b1, 1'b0);
      chk("high_kept", high_score, 16'h0005);
      pulses(3);
      miss();
      miss();
      miss();
      chk_all("over3", 1'b1, 16'h0003, 2'd0, 1'b0, 1'b1);
      chk("high_not_lowered", high_score, 16'h0005);
      press();
      pulses(7);
      miss();
      miss();
      correct   = 1'b1;
      game_over = 1'b1;
      tick();
      correct   = 1'b0;
      game_over = 1'b0;
      tick();
      chk_all("simul", 1'b1, 16'h0008, 2'd0, 1'b0, 1'b1);
      chk("simul_high", high_score, 16'h0008);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/score_lives_keeper.md
Name: score_lives_keeper

Overview:
- Game-level controller directly downstream of the falling-letter column machine.
- Consumes the column's correct and game_over outputs and keeps a 4-digit BCD score, a high score and a life counter.
- Drives the column's active-high hold/reset input: holds the column before a game starts, between lives, and after the game ends.
- Outputs feed the seven-segment and LED display stages.

Parameters:
LIVES, 3, lives loaded at reset and at every game start (1..2^LIVES_W-1)
LIVES_W, 2, width of lives output
RESPAWN_CYCLES, 25000000, cycles column_hold stays high after a lost life (>=2)

Ports:
clock  in  1  system clock, all state on rising edge
reset_signal  in  1  asynchronous, active-low reset
start_button  in  1  raw pushbutton, active-high, asynchronous to clock
correct  in  1  column "letter matched" indication (level, normally 1 cycle wide)
game_over  in  1  column "letter reached bottom" indication (level)
column_hold  out  1  to column reset input; 1 = hold column in its start state
score  out  16  packed BCD, 4 digits [15:12] thousands .. [3:0] units
high_score  out  16  packed BCD, best completed-game score since reset
lives  out  LIVES_W  remaining lives
playing  out  1  1 in PLAYING and RESPAWN states
game_ended  out  1  1 in OVER state

Behaviour:
- All outputs registered. Reset (reset_signal=0) forces, immediately:
  - state=IDLE, score=0, high_score=0, lives=LIVES
  - column_hold=1, playing=0, game_ended=0
  - synchroniser and edge registers=0, respawn counter=0
- start_button input path:
  - 2-flop synchroniser, then rising-edge detect producing start_pulse.
  - start_pulse is asserted in the cycle after the 2nd sync flop first captures 1.
  - The state change therefore happens on the 3rd rising edge after the button rises.
- correct_rise = correct & ~correct_d; miss_rise = game_over & ~game_over_d. correct_d and game_over_d are registered every cycle.
- A held-high input counts once.
- State machine:
  - IDLE: column_hold=1. On start_pulse -> PLAYING; score<=0, lives<=LIVES.
  - PLAYING: column_hold=0.
    - On correct_rise: score BCD +1 with per-digit carry; 9999 saturates, no wrap.
    - On miss_rise with lives>1: lives-1 -> RESPAWN, counter<=0.
    - On miss_rise with lives==1: lives<=0 -> OVER. high_score<=score if score>high_score. Packed-BCD unsigned compare is valid.
  - RESPAWN: column_hold=1; counter increments each cycle.
    - When counter==RESPAWN_CYCLES-1 -> PLAYING. column_hold is therefore high for exactly RESPAWN_CYCLES cycles.
    - The column re-enters its own reset path and picks a new letter.
  - OVER: column_hold=1, score and lives frozen. On start_pulse -> PLAYING; score<=0, lives<=LIVES. high_score is kept.
- Outputs follow state: column_hold=1 in IDLE/RESPAWN/OVER; playing and game_ended as defined in Ports.
- correct_rise and miss_rise are ignored outside PLAYING. This covers any glitch from the column while it is held.
- start_pulse is ignored in PLAYING and RESPAWN. No restart mid-game.
- Simultaneous correct_rise and miss_rise in PLAYING:
  - The score increment is applied first, then the miss handling.
  - When the miss ends the game, the high-score compare uses the incremented value.
- Async reset mid-game returns to IDLE and clears high_score.
- Width rule: LIVES must fit LIVES_W; lives never decrements below 0.

Test Plan:
- Reset then start pulse: start_button high 5 cycles -> IDLE->PLAYING on 3rd edge; column_hold 1->0; score=0x0000, lives=3.
- 12 one-cycle correct pulses -> score=0x0012. Then preload 0x0999 + 1 pulse -> 0x1000. Preload 0x9999 + pulse -> stays 0x9999.
- correct held high 10 cycles -> score +1 only.
- game_over pulse with lives=3 (RESPAWN_CYCLES=4 in bench) -> lives=2; column_hold=1 for exactly 4 cycles, then PLAYING. correct pulses during RESPAWN leave score unchanged.
- Score 0x0005, three misses -> OVER, lives=0, game_ended=1, high_score=0x0005. New start -> score=0, lives=3, high_score stays 0x0005. End next game at 0x0003 -> high_score stays 0x0005.
- correct and game_over rise in same cycle at lives=1, score 0x0007 -> score=0x0008, high_score=0x0008, OVER.
- reset_signal low mid-RESPAWN -> all outputs at reset values immediately; start presses during PLAYING are ignored.
